// File: rtl/nn_layer_mvm_param.sv
// nn_layer_mvm_param
// Fully-connected layer y = act(W*x + b) with a single pipelined MAC.
// Buffers one N-element input vector, then computes M rows one at a time
// and hands each result off on a valid/ready stream. Weights and biases
// live in external synchronous ROMs (1-cycle read latency).
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   s_valid/s_ready     input stream handshake, data_in = vector element
//   m_valid/m_ready     output stream handshake, data_out = row result
//   w_addr/w_data       weight ROM, row-major address r*N+k
//   b_addr/b_data       bias ROM, address r
module nn_layer_mvm_param #(
  parameter int M    = 10,
  parameter int N    = 8,
  parameter int T    = 16,
  parameter int FRAC = 0,
  parameter int RELU = 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                s_valid,
  output logic                                s_ready,
  input  logic [T-1:0]                        data_in,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic [T-1:0]                        data_out,
  output logic [$clog2(M*N)-1:0]              w_addr,
  input  logic [T-1:0]                        w_data,
  output logic [((M > 1) ? $clog2(M) : 1)-1:0] b_addr,
  input  logic [T-1:0]                        b_data
);

  localparam int WA_W  = $clog2(M*N);
  localparam int RW    = (M > 1) ? $clog2(M) : 1;
  localparam int KW    = $clog2(N);
  localparam int CW    = $clog2(N + 4);
  localparam int ACC_W = 2*T + $clog2(N) + 1;

  localparam logic [KW-1:0] K_LAST      = KW'(N - 1);
  localparam logic [RW-1:0] R_LAST      = RW'(M - 1);
  localparam logic [CW-1:0] C_N         = CW'(N);
  localparam logic [CW-1:0] C_ADDR_LAST = CW'(N - 1);
  localparam logic [CW-1:0] C_ACC_LO    = CW'(2);
  localparam logic [CW-1:0] C_ACC_HI    = CW'(N + 1);
  localparam logic [CW-1:0] C_RES       = CW'(N + 2);

  typedef enum logic [1:0] {LOAD = 2'd0, COMPUTE = 2'd1, OUTPUT = 2'd2} state_t;

  state_t                   state_r;
  logic [KW-1:0]            k_r;
  logic [RW-1:0]            r_r;
  logic [CW-1:0]            c_r;
  logic [T-1:0]             x_buf_r [N];
  logic [T-1:0]             x_q_r;
  logic signed [2*T-1:0]    prod_r;
  logic signed [ACC_W-1:0]  acc_r;

  logic signed [2*T-1:0]    w_ext_s;
  logic signed [2*T-1:0]    x_ext_s;
  logic signed [ACC_W-1:0]  prod_ext_s;
  logic signed [ACC_W-1:0]  shifted_s;
  logic signed [ACC_W:0]    sum_s;
  logic [T-1:0]             sat_s;
  logic [T-1:0]             result_s;

  // Clamp a wide signed value into the T-bit signed range.
  function automatic logic [T-1:0] sat_t(input logic signed [ACC_W:0] v);
    logic signed [ACC_W:0] hi;
    logic signed [ACC_W:0] lo;
    hi = {{(ACC_W+2-T){1'b0}}, {(T-1){1'b1}}};
    lo = {{(ACC_W+2-T){1'b1}}, {(T-1){1'b0}}};
    if (v > hi) begin
      sat_t = hi[T-1:0];
    end else if (v < lo) begin
      sat_t = lo[T-1:0];
    end else begin
      sat_t = v[T-1:0];
    end
  endfunction

  // Sign extension for the MAC and the scale/bias/saturate/activate path.
  always_comb begin
    w_ext_s    = {{T{w_data[T-1]}}, w_data};
    x_ext_s    = {{T{x_q_r[T-1]}}, x_q_r};
    prod_ext_s = {{(ACC_W-2*T){prod_r[2*T-1]}}, prod_r};
    shifted_s  = acc_r >>> FRAC;
    sum_s      = {shifted_s[ACC_W-1], shifted_s} + {{(ACC_W+1-T){b_data[T-1]}}, b_data};
    sat_s      = sat_t(sum_s);
    if ((RELU != 0) && sat_s[T-1]) begin
      result_s = '0;
    end else begin
      result_s = sat_s;
    end
  end

  // Input vector buffer; contents are only meaningful after a full LOAD.
  always_ff @(posedge clk) begin
    if (state_r == LOAD && s_valid && s_ready) begin
      x_buf_r[k_r] <= data_in;
    end
  end

  // Main sequencer: load vector, run the MAC pipeline per row, hand off results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= LOAD;
      k_r      <= '0;
      r_r      <= '0;
      c_r      <= '0;
      x_q_r    <= '0;
      prod_r   <= '0;
      acc_r    <= '0;
      s_ready  <= 1'b0;
      m_valid  <= 1'b0;
      data_out <= '0;
      w_addr   <= '0;
      b_addr   <= '0;
    end else begin
      case (state_r)
        LOAD: begin
          s_ready <= 1'b1;
          if (s_valid && s_ready) begin
            if (k_r == K_LAST) begin
              // Last element: drop s_ready on this edge and present row 0's
              // first weight address so the ROM read starts in cycle c0.
              state_r <= COMPUTE;
              s_ready <= 1'b0;
              k_r     <= '0;
              r_r     <= '0;
              c_r     <= '0;
              acc_r   <= '0;
              w_addr  <= '0;
              b_addr  <= '0;
            end else begin
              k_r <= k_r + KW'(1);
            end
          end
        end
        COMPUTE: begin
          c_r <= c_r + CW'(1);
          // Stage 1: x read alongside the ROM read issued in cycle c.
          if (c_r < C_N) begin
            x_q_r <= x_buf_r[c_r[KW-1:0]];
          end
          // w_addr stops on the row's last address; the next row's base is
          // simply one more, so no multiply is needed.
          if (c_r < C_ADDR_LAST) begin
            w_addr <= w_addr + WA_W'(1);
          end
          // Stage 2: product; only products from cycles 1..N are accumulated.
          prod_r <= w_ext_s * x_ext_s;
          if (c_r >= C_ACC_LO && c_r <= C_ACC_HI) begin
            acc_r <= acc_r + prod_ext_s;
          end
          if (c_r == C_RES) begin
            data_out <= result_s;
            m_valid  <= 1'b1;
            state_r  <= OUTPUT;
          end
        end
        OUTPUT: begin
          if (m_valid && m_ready) begin
            m_valid <= 1'b0;
            if (r_r == R_LAST) begin
              state_r <= LOAD;
              k_r     <= '0;
              s_ready <= 1'b1;
            end else begin
              state_r <= COMPUTE;
              r_r     <= r_r + RW'(1);
              b_addr  <= r_r + RW'(1);
              w_addr  <= w_addr + WA_W'(1);
              c_r     <= '0;
              acc_r   <= '0;
            end
          end
        end
        default: begin
          state_r <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nn_layer_mvm_param.sv
// Directed testbench for nn_layer_mvm_param (M=2, N=3, T=16).
// Three instances run in lockstep on the same stimulus: ReLU/FRAC=0,
// identity/FRAC=0 and identity/FRAC=4, each with its own ROM read port.
module tb_nn_layer_mvm_param;

  localparam int M = 2;
  localparam int N = 3;
  localparam int T = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        s_valid;
  logic        m_ready;
  logic [15:0] data_in;

  logic               s_ready_a, s_ready_b, s_ready_c;
  logic               m_valid_a, m_valid_b, m_valid_c;
  logic signed [15:0] data_out_a, data_out_b, data_out_c;
  logic [2:0]         w_addr_a, w_addr_b, w_addr_c;
  logic [0:0]         b_addr_a, b_addr_b, b_addr_c;
  logic [15:0]        w_data_a, w_data_b, w_data_c;
  logic [15:0]        b_data_a, b_data_b, b_data_c;

  logic signed [15:0] w_rom [M*N];
  logic signed [15:0] b_rom [M];

  int n_checks = 0;
  int n_fail   = 0;

  nn_layer_mvm_param #(.M(M), .N(N), .T(T), .FRAC(0), .RELU(1)) u_relu (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready_a),
    .data_in(data_in), .m_valid(m_valid_a), .m_ready(m_ready),
    .data_out(data_out_a), .w_addr(w_addr_a), .w_data(w_data_a),
    .b_addr(b_addr_a), .b_data(b_data_a));

  nn_layer_mvm_param #(.M(M), .N(N), .T(T), .FRAC(0), .RELU(0)) u_lin (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready_b),
    .data_in(data_in), .m_valid(m_valid_b), .m_ready(m_ready),
    .data_out(data_out_b), .w_addr(w_addr_b), .w_data(w_data_b),
    .b_addr(b_addr_b), .b_data(b_data_b));

  nn_layer_mvm_param #(.M(M), .N(N), .T(T), .FRAC(4), .RELU(0)) u_frac (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready_c),
    .data_in(data_in), .m_valid(m_valid_c), .m_ready(m_ready),
    .data_out(data_out_c), .w_addr(w_addr_c), .w_data(w_data_c),
    .b_addr(b_addr_c), .b_data(b_data_c));

  // Synchronous ROM models, one read port per instance.
  always @(posedge clk) begin
    w_data_a <= w_rom[w_addr_a];
    w_data_b <= w_rom[w_addr_b];
    w_data_c <= w_rom[w_addr_c];
    b_data_a <= b_rom[b_addr_a];
    b_data_b <= b_rom[b_addr_b];
    b_data_c <= b_rom[b_addr_c];
  end

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_rom(input int w0, input int w1, input int w2,
                          input int w3, input int w4, input int w5,
                          input int b0, input int b1);
    w_rom[0] = 16'(w0); w_rom[1] = 16'(w1); w_rom[2] = 16'(w2);
    w_rom[3] = 16'(w3); w_rom[4] = 16'(w4); w_rom[5] = 16'(w5);
    b_rom[0] = 16'(b0); b_rom[1] = 16'(b1);
  endtask

  // Present x0..x2 with 'gap' idle cycles before each word; returns just
  // after the edge that accepts the last word (COMPUTE entry edge).
  task automatic send_vec(input int x0, input int x1, input int x2, input int gap);
    int xs [3];
    int t;
    xs[0] = x0; xs[1] = x1; xs[2] = x2;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b0;
      repeat (gap) step();
      s_valid = 1'b1;
      data_in = 16'(xs[i]);
      t = 0;
      while (!s_ready_a && t < 20) begin
        step();
        t++;
      end
      if (t >= 20) check("s_ready_timeout", 0, 1);
      step();
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_mvalid(output int cyc);
    cyc = 0;
    while (!m_valid_a && cyc < 40) begin
      step();
      cyc++;
    end
    if (!m_valid_a) check("m_valid_timeout", 0, 1);
  endtask

  // Wait for a row, check all three results, then hand it off (m_ready=1).
  task automatic take_row(input string tag, input int ea, input int eb,
                          input int ec, input int exp_lat);
    int cyc;
    wait_mvalid(cyc);
    if (exp_lat >= 0) check({tag, "_latency"}, cyc, exp_lat);
    check({tag, "_relu"}, data_out_a, ea);
    check({tag, "_lin"}, data_out_b, eb);
    check({tag, "_frac"}, data_out_c, ec);
    check({tag, "_s_ready_low"}, {31'd0, s_ready_a}, 0);
    step();
    check({tag, "_m_valid_drop"}, {31'd0, m_valid_a}, 0);
  endtask

  initial begin
    int cyc;
    reset   = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b1;
    data_in = 16'd0;
    load_rom(1, 1, 1, -1, 0, 0, 4, 0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", {31'd0, s_ready_a}, 0);
    check("rst_m_valid", {31'd0, m_valid_a}, 0);
    check("rst_data_out", data_out_a, 0);
    check("rst_w_addr", {29'd0, w_addr_a}, 0);
    check("rst_b_addr", {31'd0, b_addr_a}, 0);
    reset = 1'b0;
    check("s_ready_before_edge", {31'd0, s_ready_a}, 0);
    step();
    check("s_ready_after_edge", {31'd0, s_ready_a}, 1);

    // Basic vector: y = [10, -1] before activation
    send_vec(1, 2, 3, 0);
    take_row("t1r0", 10, 10, 4, 6);
    take_row("t1r1", 0, -1, -1, 6);
    check("t1_s_ready_back", {31'd0, s_ready_a}, 1);

    // Same vector with input gaps
    send_vec(1, 2, 3, 2);
    take_row("gap_r0", 10, 10, 4, -1);
    take_row("gap_r1", 0, -1, -1, -1);

    // Saturation, followed back-to-back by a second vector on the same ROM
    load_rom(2, 2, 2, -2, -2, -2, 0, 0);
    send_vec(32767, 32767, 32767, 0);
    take_row("sat_r0", 32767, 32767, 12287, -1);
    take_row("sat_r1", 0, -32768, -12288, -1);
    send_vec(1, 2, 3, 0);
    take_row("b2b_r0", 12, 12, 0, -1);
    take_row("b2b_r1", 0, -12, -1, -1);

    // Fixed-point scaling with 5 cycles of backpressure on row 0
    load_rom(16, 16, 16, -16, -16, -16, 1, 1);
    m_ready = 1'b0;
    send_vec(16, 16, 16, 0);
    wait_mvalid(cyc);
    check("bp_latency", cyc, 6);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_frac", data_out_c, 49);
      check("bp_hold_relu", data_out_a, 769);
      check("bp_hold_m_valid", {31'd0, m_valid_a}, 1);
      check("bp_hold_s_ready", {31'd0, s_ready_a}, 0);
      step();
    end
    check("bp_lin", data_out_b, 769);
    m_ready = 1'b1;
    step();
    check("bp_handshake", {31'd0, m_valid_a}, 0);
    take_row("bp_r1", 0, -767, -47, 6);

    // Reset in the middle of row 1
    load_rom(1, 1, 1, -1, 0, 0, 4, 0);
    send_vec(1, 2, 3, 0);
    take_row("pre_rst_r0", 10, 10, 4, -1);
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    check("midrst_m_valid", {31'd0, m_valid_a}, 0);
    check("midrst_data_out", data_out_a, 0);
    check("midrst_s_ready", {31'd0, s_ready_a}, 0);
    check("midrst_w_addr", {29'd0, w_addr_a}, 0);
    check("midrst_b_addr", {31'd0, b_addr_a}, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    check("post_rst_s_ready", {31'd0, s_ready_a}, 1);
    check("post_rst_no_output", {31'd0, m_valid_a}, 0);
    load_rom(16, 16, 16, -16, -16, -16, 1, 1);
    send_vec(16, 16, 16, 0);
    take_row("post_rst_r0", 769, 769, 49, 6);
    take_row("post_rst_r1", 0, -767, -47, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nn_layer_mvm_param.md
# nn_layer_mvm_param

Parametrised fully-connected neural-network layer: buffers one N-element input vector from a valid/ready stream, then computes y = act(W·x + b) for M output rows with a pipelined single-MAC datapath. Emits results row by row on a valid/ready output stream. Weight and bias storage is external (synchronous ROMs addressed by this block), so one RTL body serves every generated layer size. Adds three things over the fixed 10×8 layer:
- configurable width and fixed-point scaling;
- saturating output arithmetic;
- selectable ReLU/identity activation.

## Interface
- M, 10, number of output rows (≥1)
- N, 8, input vector length (≥2)
- T, 16, data/weight/bias width, signed two's complement
- FRAC, 0, fractional bits; the dot product is arithmetic-right-shifted by FRAC before bias add
- RELU, 1, 1 = ReLU on output, 0 = identity
- clk  in  1  clock, all logic on rising edge
- reset  in  1  one clock; reset is asynchronous and active-high
- s_valid  in  1  input word valid
- s_ready  out  1  block accepts input word
- data_in  in  T  input vector element, signed
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accepts output
- data_out  out  T  output element, signed
- w_addr  out  clog2(M*N)  weight ROM address, row-major (r*N+k)
- w_data  in  T  weight ROM data, 1-cycle read latency
- b_addr  out  clog2(M)  bias ROM address
- b_data  in  T  bias ROM data, 1-cycle read latency

## Operation
- States: LOAD, COMPUTE, OUTPUT.
- LOAD:
  - s_ready=1.
  - Each s_valid&&s_ready writes data_in to x buffer[k], then k++.
  - After the N-th accept, go to COMPUTE with r=0. s_ready drops on the same edge.
- COMPUTE (row r):
  - Sequencer issues k=0..N-1, driving w_addr=r*N+k and x read address k. b_addr=r is held.
  - Pipeline: ROM/x read → registered product (2T bits) → accumulate.
  - Accumulator is ACC_W = 2T+clog2(N)+1 bits, so it never overflows. It is cleared at row start.
  - Result = sat_T((acc >>> FRAC) + sign_ext(b_data)).
  - sat_T clamps to [−2^(T−1), 2^(T−1)−1].
  - If RELU=1, negative results become 0.
  - The result is registered into data_out, m_valid=1, and the state goes to OUTPUT.
- OUTPUT:
  - data_out and m_valid are held stable until m_valid&&m_ready.
  - On handshake: if r<M−1, go to COMPUTE with r+1; else go to LOAD with k=0.
- Input words presented outside LOAD are not accepted (s_ready=0). The upstream holds them.

## Timing
- Reset (async, any state) forces:
  - state=LOAD, k=r=0, accumulator=0;
  - s_ready=0, m_valid=0, data_out=0, w_addr=0, b_addr=0.
- Reset mid-vector or mid-row discards all partial data. No output is produced for the aborted vector.
- s_ready rises on the first clock edge after reset deasserts.
- LOAD accepts at most one word per cycle. A gap in s_valid only stalls; no data is lost.
- COMPUTE entry cycle is c=0, with address k=0 driven in c0. Address k is driven in cycle c=k.
  - Product for k is registered at the end of c=k+1.
  - It is accumulated at the end of c=k+2.
  - Final accumulate is at the end of c=N+1.
  - Bias add, saturate and activate are registered at the end of c=N+2.
  - m_valid is high from c=N+3.
- Per-row latency is N+3 cycles from COMPUTE entry to m_valid.
- With m_ready tied high:
  - each row takes N+4 cycles (handshake in the first m_valid cycle);
  - the next COMPUTE starts the following cycle.
- After the handshake on row M−1, s_ready=1 in the next cycle.
- With m_ready held high, a handshake completes in the first m_valid cycle.
- The block never takes data_in and presents data_out in the same cycle. A new vector is not loaded until all M rows have been handed off.
- w_addr and b_addr are don't-care outside COMPUTE but are held at their last value, so the ROMs see no spurious toggles.

## Test plan
- M=2,N=3,T=16,FRAC=0,RELU=1; x=[1,2,3]; W=[[1,1,1],[−1,0,0]]; b=[4,0]; m_ready=1.
  - Required outputs: 10 then 0.
  - m_valid asserts 6 cycles after COMPUTE entry.
- Same vectors with RELU=0 → outputs 10 then −1.
- Saturation, T=16, N=3, RELU=0:
  - x=[32767]*3, W row=[2,2,2], b=0 → 32767.
  - W row=[−2,−2,−2] → −32768.
- FRAC=4: x=[16,16,16], W=[16,16,16], b=1 → (768>>>4)+1 = 49.
- Backpressure: hold m_ready=0 for 5 cycles while m_valid=1.
  - data_out is stable and s_ready=0 throughout.
  - One handshake when m_ready=1, then the next row proceeds.
- Stalls and reset:
  - Insert s_valid gaps during LOAD → results unchanged.
  - Assert reset during COMPUTE row 1 → all outputs 0 immediately.
  - A fresh vector afterwards yields correct row 0 first.
  - Two back-to-back vectors give 2M correct outputs in order.
